// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Brief    : Fibonacci LFSR sequence source with a valid/ready output.
//            Supports reseed (load), wrap detection against the start value,
//            and STEPS single-bit shifts per accepted advance.
//            Optional build macro LFSR_LOCKUP_RECOVER_EN compiles in all-zero
//            state recovery (substitutes SEED and pulses lockup).
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int unsigned      STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             lockup
);

    // Advance counter is wide enough never to saturate within one full period.
    localparam int unsigned c_CNT_W = WIDTH + 6;

    logic [WIDTH-1:0]   r_state;
    logic [WIDTH-1:0]   r_start;
    logic               r_valid;
    logic               r_wrap;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_hs;
    logic               w_upd;
    logic               w_match;
    logic               w_cnt_max;
    logic [WIDTH-1:0]   w_adv;
    logic [WIDTH-1:0]   w_cand;
    logic [WIDTH-1:0]   w_next;

    // The consumer takes q only when it is valid and no reseed competes.
    assign w_hs  = r_valid & out_ready & ~load;
    assign w_upd = load | w_hs;

    // Apply STEPS Fibonacci shifts to the current state in one cycle.
    always_comb begin
        logic [WIDTH-1:0] v_s;
        v_s = r_state;
        for (int k = 0; k < STEPS; k++) begin
            v_s = {v_s[WIDTH-2:0], ^(v_s & TAPS)};
        end
        w_adv = v_s;
    end

    // A reseed overrides any advance offered in the same cycle.
    assign w_cand = load ? data : w_adv;

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic w_zero;
    logic w_lk;
    logic r_lockup;

    assign w_zero = (w_cand == '0);
    assign w_next = w_zero ? SEED : w_cand;
    assign w_lk   = w_upd & w_zero;

    // Flag, one cycle later, that an all-zero value was replaced by SEED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_lk;
        end
    end

    assign lockup = r_lockup;
`else
    // Without recovery an all-zero value is stored as-is and the LFSR sticks.
    assign w_next = w_cand;
    assign lockup = 1'b0;
`endif

    // Wrap: an accepted advance lands back on the value the sequence began at.
    assign w_match   = w_hs & (w_next == r_start);
    assign w_cnt_max = &r_cnt;

    // Sequence state: reseed or advance, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (w_upd) begin
            r_state <= w_next;
        end
    end

    // Start value of the current sequence, refreshed on each reseed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start <= SEED;
        end else if (load) begin
            r_start <= w_next;
        end
    end

    // Output is valid except in the single bubble cycle after a reseed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= ~load;
        end
    end

    // One-cycle wrap pulse; never raised by a load since w_hs excludes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_match;
        end
    end

    // Saturating count of advances since reset, reseed or the last wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (w_hs) begin
            if (w_match) begin
                r_cnt <= '0;
            end else if (!w_cnt_max) begin
                r_cnt <= r_cnt + {{(c_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign q         = r_state;
    assign out_valid = r_valid;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16: state/output width; legal range 3..64.
REQ-002 SHALL have parameter TAPS, default 16'hB400: Fibonacci feedback mask (bit i set = state[i] XORed into feedback).
REQ-003 SHALL have parameter SEED, default 16'hACE1: reset state; nonzero.
REQ-004 SHALL have parameter STEPS, default 1: single-bit shifts applied per accepted advance; legal range 1..WIDTH.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port load  input  1  reseed strobe.
REQ-008 SHALL have port data  input  WIDTH  reseed value, sampled when load=1.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the current q.
REQ-010 SHALL have port out_valid  output  1  q holds a valid sequence value.
REQ-011 SHALL have port q  output  WIDTH  current LFSR state, registered.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse: sequence returned to its start value.
REQ-013 SHALL have port lockup  output  1  one-cycle pulse: an all-zero state was rejected (recovery build only).

Function
REQ-014 SHALL define one step as fb = XOR over i of (state[i] AND TAPS[i]), then state <= {state[WIDTH-2:0], fb}.
REQ-015 SHALL, on handshake (out_valid=1 and out_ready=1 and load=0), apply exactly STEPS steps combinationally, registering the result next edge; latency 1 cycle.
REQ-016 SHALL hold q unchanged whenever no handshake and no load occur.
REQ-017 SHALL, on load=1, register data into the state next edge regardless of out_valid/out_ready; load wins over a simultaneous handshake, whose advance is discarded.
REQ-018 SHALL drive out_valid=0 for exactly the one cycle following a load edge (reseed bubble), then 1; back-to-back loads keep it 0.
REQ-019 SHALL hold a start register equal to SEED after reset and to the loaded value after each load.
REQ-020 SHALL maintain an advance counter (WIDTH+6 bits, saturating) cleared on reset/load, incremented per handshake.
REQ-021 SHALL pulse wrap for one cycle, in the cycle after the handshake whose result equals the start register, and SHALL then clear the advance counter.
REQ-022 SHALL never pulse wrap on a load or reset edge, even if data equals the previous start value.
REQ-023 SHALL keep lockup=0 in all cycles when the recovery feature is compiled out.

Reset
REQ-024 SHALL, while rst=0, force q=SEED, start=SEED, out_valid=0, wrap=0, lockup=0, counter=0, asynchronously.
REQ-025 SHALL assert out_valid=1 on the first rising clk edge after rst deasserts.
REQ-026 SHALL, on rst assertion mid-transfer, discard any pending load or advance.

Configuration
REQ-027 SHALL use macro LFSR_LOCKUP_RECOVER_EN to compile in all-zero recovery.
REQ-028 SHALL, with LFSR_LOCKUP_RECOVER_EN defined, replace any all-zero value being registered (load or step result) with SEED, and pulse lockup for one cycle in the following cycle; start register takes the substituted value.
REQ-029 SHALL, without LFSR_LOCKUP_RECOVER_EN, register all-zero values unchanged, leaving the LFSR stuck at 0 (advances yield 0).

Verification
REQ-030 SHALL cover: reset with defaults -> q=16'hACE1, out_valid=0 during reset, 1 one cycle after release.
REQ-031 SHALL cover: load 16'h0001, wait bubble, one handshake -> q=16'h0002; load 16'h8000, one handshake -> q=16'h0001.
REQ-032 SHALL cover: defaults, continuous out_ready=1 from reset -> wrap pulses exactly once after 65535 handshakes, q=16'hACE1 then.
REQ-033 SHALL cover: STEPS=4, load 16'h0001, one handshake -> q=16'h0010.
REQ-034 SHALL cover: load=1 with out_ready=1 in same cycle, data=16'h1234 -> q=16'h1234, no advance, out_valid=0 next cycle.
REQ-035 SHALL cover: load 16'h0000 -> with LFSR_LOCKUP_RECOVER_EN q=16'hACE1 and lockup pulse; without it q stays 16'h0000 after 10 handshakes, lockup=0.
